// File: rtl/fifo_wr_arbiter_pkg.sv
// ------------------------------------------------------------------
// fifo_arb_pkg: shared types and width helpers for fifo_wr_arbiter.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STALL_CNT_W = 16;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int beat_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ------------------------------------------------------------------
// rr_pick: combinational round-robin picker, first set bit at or above ptr (wrapping).
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  int cand;

  // Scan from the farthest offset down so the nearest match wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand[GRANT_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ------------------------------------------------------------------
// fifo_wr_arbiter: round-robin bounded-burst arbiter for a FIFO write port.
// Optional macro WR_ARB_STATS_EN adds the stall_cnt output. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [grant_w(NUM_REQ)-1:0]   grant_id,
`ifdef WR_ARB_STATS_EN
  output logic [STALL_CNT_W-1:0]        stall_cnt,
`endif
  output logic                          busy
);

  localparam int GRANT_W = grant_w(NUM_REQ);
  localparam int BEAT_W  = beat_w(MAX_BURST);
  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0]  BEAT_MAX = BEAT_W'(MAX_BURST);

  arb_state_e         state, state_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [GRANT_W-1:0] rr_ptr, rr_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt, beat_inc;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_found;
  logic               cur_valid, cur_last, xfer, done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign beat_inc  = beat_cnt + BEAT_W'(1);
  assign xfer      = (state == BURST) && cur_valid && !full;
  // While full the grant is frozen; otherwise an empty slot also ends the burst.
  assign done      = (state == BURST) && !full &&
                     (!cur_valid || cur_last || (beat_inc == BEAT_MAX));

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    beat_nxt  = beat_cnt;
    rr_nxt    = rr_ptr;
    req_ready = '0;
    wr_en     = 1'b0;
    data_in   = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BURST;
          grant_nxt = pick_idx;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[grant_id] = !full;
        wr_en               = xfer;
        data_in             = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        if (xfer) begin
          beat_nxt = beat_inc;
        end
        if (done) begin
          state_nxt = IDLE;
          rr_nxt    = (grant_id == LAST_IDX) ? '0 : grant_id + GRANT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef WR_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Counts only cycles where a word is actually waiting on a full FIFO.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state == BURST) && cur_valid && full && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ------------------------------------------------------------------
// tb_fifo_wr_arbiter: vector table, corner sequences and randomized model check.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last;
  logic [31:0] req_data;
  logic        full;
  wire  [3:0]  req_ready;
  wire         wr_en;
  wire  [7:0]  data_in;
  wire  [1:0]  grant_id;
  wire         busy;

  logic [2:0]  b_valid = 3'b111;
  logic [23:0] b_data  = 24'h332211;
  logic [2:0]  b_last  = 3'b000;
  logic        b_full  = 1'b0;
  wire  [2:0]  b_ready;
  wire         b_wr;
  wire  [7:0]  b_din;
  wire  [1:0]  b_gid;
  wire         b_busy;
`ifdef WR_ARB_STATS_EN
  wire  [15:0] stall_cnt, b_stall;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk_wr    (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .grant_id  (grant_id),
`ifdef WR_ARB_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(1)) dut_b (
    .clk_wr    (clk),
    .rst_n     (rst_n),
    .req_valid (b_valid),
    .req_data  (b_data),
    .req_last  (b_last),
    .req_ready (b_ready),
    .full      (b_full),
    .wr_en     (b_wr),
    .data_in   (b_din),
    .grant_id  (b_gid),
`ifdef WR_ARB_STATS_EN
    .stall_cnt (b_stall),
`endif
    .busy      (b_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        wr;
    logic [7:0]  din;
    logic [3:0]  rdy;
    logic        bsy;
    logic [1:0]  gid;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic f, input logic wr, input logic [7:0] din,
                              input logic [3:0] rdy, input logic bsy, input logic [1:0] gid);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.f = f; r.wr = wr;
    r.din = din; r.rdy = rdy; r.bsy = bsy; r.gid = gid;
    return r;
  endfunction

  vec_t tbl[$];

  // Reference model state: owner -1 means no grant held.
  int         owner, beats, nextp, lastg, stall_m;
  bit         rv[4];
  bit         rl[4];
  logic [7:0] rd[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with every requester asserting valid.
    rst_n = 1'b0; req_valid = 4'hF; req_last = 4'h0; req_data = 32'hDEADBEEF; full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_data",  32'(data_in), 32'h0);
    rst_n = 1'b1;

    //        v      l      d              f  wr  din    rdy    bsy gid
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000A1, 0, 0, 8'h00, 4'h0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000A1, 0, 1, 8'hA1, 4'h1, 1, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000A2, 0, 1, 8'hA2, 4'h1, 1, 0));
    tbl.push_back(mk(4'h1, 4'h1, 32'h000000A3, 0, 1, 8'hA3, 4'h1, 1, 0));
    tbl.push_back(mk(4'h3, 4'h3, 32'h0000B1A4, 0, 0, 8'h00, 4'h0, 0, 0));
    tbl.push_back(mk(4'h3, 4'h3, 32'h0000B1A4, 0, 1, 8'hB1, 4'h2, 1, 1));
    tbl.push_back(mk(4'h1, 4'h1, 32'h000000A4, 0, 0, 8'h00, 4'h0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h1, 32'h000000A4, 0, 1, 8'hA4, 4'h1, 1, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000C1, 0, 0, 8'h00, 4'h0, 0, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000C1, 0, 1, 8'hC1, 4'h1, 1, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000C2, 0, 1, 8'hC2, 4'h1, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'h1, 4'h0, 32'h000000C3, 1, 0, 8'hC3, 4'h0, 1, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000C3, 0, 1, 8'hC3, 4'h1, 1, 0));
    tbl.push_back(mk(4'h1, 4'h0, 32'h000000C4, 0, 1, 8'hC4, 4'h1, 1, 0));
    tbl.push_back(mk(4'h4, 4'h4, 32'h00E10000, 0, 0, 8'h00, 4'h0, 0, 0));
    tbl.push_back(mk(4'h4, 4'h4, 32'h00E10000, 0, 1, 8'hE1, 4'h4, 1, 2));
    tbl.push_back(mk(4'hA, 4'hA, 32'hF100B200, 0, 0, 8'h00, 4'h0, 0, 2));
    tbl.push_back(mk(4'hA, 4'hA, 32'hF100B200, 0, 1, 8'hF1, 4'h8, 1, 3));
    tbl.push_back(mk(4'h2, 4'h2, 32'h0000B200, 0, 0, 8'h00, 4'h0, 0, 3));
    tbl.push_back(mk(4'h2, 4'h2, 32'h0000B200, 0, 1, 8'hB2, 4'h2, 1, 1));
    tbl.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h0, 32'h00000061, 0, 0, 8'h00, 4'h0, 0, 1));
    tbl.push_back(mk(4'h1, 4'h0, 32'h00000061, 0, 1, 8'h61, 4'h1, 1, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h1, 1, 0));
    tbl.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 0, 0));

    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_last = tbl[i].l; req_data = tbl[i].d; full = tbl[i].f;
      #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_data", i),  32'(data_in), 32'(tbl[i].din));
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_busy", i),  32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(tbl[i].gid));
      @(posedge clk);
      #1;
    end
`ifdef WR_ARB_STATS_EN
    chk("stall_cnt_after_vec", 32'(stall_cnt), 32'd5);
`endif

    // Randomized run against the model; NUM_REQ=3 instance checked in its first cycles.
    req_valid = 4'h0; full = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    owner = -1; beats = 0; nextp = 0; lastg = 0; stall_m = 0;
    for (int i = 0; i < 4; i++) begin rv[i] = 0; rl[i] = 0; rd[i] = 8'h00; end

    for (int c = 0; c < 4000; c++) begin
      logic [3:0] erdy;
      logic       ewr, found;
      logic [7:0] edin;
      int         o, cand;
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && ($urandom_range(3) != 0)) begin
          rv[i] = 1;
          rd[i] = 8'($urandom);
          rl[i] = ($urandom_range(5) == 0);
        end
        req_valid[i] = rv[i];
        req_last[i]  = rl[i];
        req_data[i*8 +: 8] = rd[i];
      end
      if ($urandom_range(7) == 0) full = ~full;
      #1;
      erdy = 4'h0;
      if (owner >= 0 && !full) erdy[owner] = 1'b1;
      ewr  = (owner >= 0) && rv[owner] && !full;
      edin = (owner >= 0) ? rd[owner] : 8'h00;
      chk("rnd_wr_en", 32'(wr_en), 32'(ewr));
      chk("rnd_data",  32'(data_in), 32'(edin));
      chk("rnd_ready", 32'(req_ready), 32'(erdy));
      chk("rnd_busy",  32'(busy), 32'(owner >= 0));
      chk("rnd_grant", 32'(grant_id), 32'(lastg));
`ifdef WR_ARB_STATS_EN
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
      if (c < 8) begin
        // NUM_REQ=3, MAX_BURST=1, all valid: grants 0,1,2,0 separated by idle cycles.
        chk("n3_busy", 32'(b_busy), 32'(c % 2));
        if (c % 2 == 1) begin
          chk("n3_grant", 32'(b_gid), 32'((c / 2) % 3));
          chk("n3_data",  32'(b_din), 32'(8'h11 * ((c / 2) % 3 + 1)));
        end
      end
      @(posedge clk);
      o = owner;
      if (o >= 0 && rv[o] && full && stall_m < 65535) stall_m++;
      if (o < 0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          cand = (nextp + k) % 4;
          if (!found && rv[cand]) begin found = 1; owner = cand; end
        end
        if (found) begin lastg = owner; beats = 0; end
      end else if (!full) begin
        if (rv[o]) begin
          beats++;
          rv[o] = 0;
          if (rl[o] || beats == 4) owner = -1;
        end else begin
          owner = -1;
        end
        if (owner < 0) nextp = (o + 1) % 4;
      end
      #1;
    end

    // Reset asserted in the middle of a burst.
    req_valid = 4'hF; req_last = 4'h0; full = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!busy) begin @(posedge clk); #1; end
    end
    chk("midrst_pre_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_busy",  32'(busy), 32'h0);
    chk("midrst_grant", 32'(grant_id), 32'h0);
    chk("midrst_data",  32'(data_in), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
